// File: rtl/vi_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : vi_ctrl_pkg                                                  |
// | Purpose   : Shared types and Q1.15 helpers for the voltage/current loop  |
// |             sequencer and its ramp datapath.                             |
// | Contents  : state_t, fault_code_t, Q15_MAX/Q15_MIN, q15_add_sat,         |
// |             q15_sub_sat.                                                 |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package vi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    CALC      = 3'd2,
    FAULT     = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE        = 2'b00,
    FC_OVERCURRENT = 2'b01,
    FC_OVERRUN     = 2'b10
  } fault_code_t;

  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  // 17-bit sum; the two top bits differ only when the 16-bit result overflowed.
  function automatic logic signed [15:0] q15_add_sat(input logic signed [15:0] a,
                                                     input logic signed [15:0] b);
    logic signed [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) return sum[16] ? Q15_MIN : Q15_MAX;
    return sum[15:0];
  endfunction

  function automatic logic signed [15:0] q15_sub_sat(input logic signed [15:0] a,
                                                     input logic signed [15:0] b);
    logic signed [16:0] diff;
    diff = {a[15], a} - {b[15], b};
    if (diff[16] != diff[15]) return diff[16] ? Q15_MIN : Q15_MAX;
    return diff[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/q15_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : q15_ramp                                                     |
// | Purpose   : One soft-start step: moves current toward target by step,    |
// |             landing exactly on target instead of overshooting.           |
// | Ports     : current (in, Q1.15), target (in, Q1.15), step (in, Q1.15,    |
// |             expected positive), next (out, Q1.15).                       |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module q15_ramp (
  input  logic signed [15:0] current,
  input  logic signed [15:0] target,
  input  logic signed [15:0] step,
  output logic signed [15:0] next
);
  import vi_ctrl_pkg::*;

  logic signed [15:0] up_val;
  logic signed [15:0] dn_val;

  assign up_val = q15_add_sat(current, step);
  assign dn_val = q15_sub_sat(current, step);

  always_comb begin
    next = current;
    if (current < target) begin
      next = (up_val > target) ? target : up_val;
    end else if (current > target) begin
      next = (dn_val < target) ? target : dn_val;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vi_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : vi_loop_sequencer                                            |
// | Purpose   : Sample-period sequencer for a V/I control loop: periodic PI  |
// |             requests, duty clamping/loading, over-current and overrun    |
// |             fault latching, reference presentation.                      |
// | Ports     : clk, rst (sync, active high), start, clear_fault,            |
// |             v_ref_tgt, i_max, i_in, calc_done, duty_in (inputs);         |
// |             calc_req, duty_out, duty_load, v_ref, fault, fault_code,     |
// |             state (outputs).                                             |
// | Options   : SOFT_START_EN - ramp v_ref from 0 by RAMP_STEP per sample.   |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module vi_loop_sequencer #(
  parameter int                 DIV       = 1000,
  parameter logic signed [15:0] RAMP_STEP = 16'sh0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear_fault,
  input  logic signed [15:0] v_ref_tgt,
  input  logic signed [15:0] i_max,
  input  logic signed [15:0] i_in,
  output logic               calc_req,
  input  logic               calc_done,
  input  logic signed [15:0] duty_in,
  output logic        [15:0] duty_out,
  output logic               duty_load,
  output logic signed [15:0] v_ref,
  output logic               fault,
  output logic        [1:0]  fault_code,
  output logic        [2:0]  state
);
  import vi_ctrl_pkg::*;

  localparam logic [15:0] TC_RELOAD = 16'(DIV - 1);

  state_t             cur_state, nxt_state;
  logic        [15:0] tick_cnt, tick_nxt;
  logic               calc_req_nxt, duty_load_nxt, fault_nxt;
  logic        [15:0] duty_nxt;
  logic signed [15:0] v_ref_nxt;
  fault_code_t        code_nxt;

  logic               over_current;
  logic               terminal;
  logic signed [15:0] v_ref_start;  // value loaded when a run starts
  logic signed [15:0] v_ref_step;   // value loaded on each accepted calc_done

`ifdef SOFT_START_EN
  q15_ramp u_ramp (
    .current (v_ref),
    .target  (v_ref_tgt),
    .step    (RAMP_STEP),
    .next    (v_ref_step)
  );
  assign v_ref_start = 16'sh0000;
`else
  assign v_ref_step  = v_ref_tgt;
  assign v_ref_start = v_ref_tgt;
`endif

  assign over_current = (i_in > i_max);
  assign terminal     = (tick_cnt == 16'd0);
  assign state        = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state  <= IDLE;
      tick_cnt   <= 16'd0;
      calc_req   <= 1'b0;
      duty_load  <= 1'b0;
      duty_out   <= 16'd0;
      v_ref      <= 16'sh0000;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      cur_state  <= nxt_state;
      tick_cnt   <= tick_nxt;
      calc_req   <= calc_req_nxt;
      duty_load  <= duty_load_nxt;
      duty_out   <= duty_nxt;
      v_ref      <= v_ref_nxt;
      fault      <= fault_nxt;
      fault_code <= code_nxt;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    tick_nxt      = tick_cnt;
    calc_req_nxt  = 1'b0;
    duty_load_nxt = 1'b0;
    duty_nxt      = duty_out;
    v_ref_nxt     = v_ref;
    fault_nxt     = fault;
    code_nxt      = fault_code_t'(fault_code);

    case (cur_state)
      IDLE: begin
        duty_nxt = 16'd0;
        if (start) begin
          nxt_state = WAIT_TICK;
          tick_nxt  = TC_RELOAD;
          v_ref_nxt = v_ref_start;
        end
      end

      WAIT_TICK, CALC: begin
        // The period counter keeps running through CALC so sample spacing
        // never depends on PI latency.
        tick_nxt = terminal ? TC_RELOAD : tick_cnt - 16'd1;
        if (over_current || (terminal && cur_state == CALC)) begin
          nxt_state     = FAULT;
          fault_nxt     = 1'b1;
          code_nxt      = over_current ? FC_OVERCURRENT : FC_OVERRUN;
          duty_nxt      = 16'd0;
          duty_load_nxt = 1'b1;
        end else if (terminal) begin
          nxt_state    = CALC;
          calc_req_nxt = 1'b1;
        end else if (cur_state == CALC && calc_done) begin
          nxt_state     = WAIT_TICK;
          duty_nxt      = duty_in[15] ? 16'd0 : duty_in;
          duty_load_nxt = 1'b1;
          v_ref_nxt     = v_ref_step;
        end
      end

      FAULT: begin
        duty_nxt = 16'd0;
        if (clear_fault && !over_current) begin
          nxt_state = IDLE;
          fault_nxt = 1'b0;
          code_nxt  = FC_NONE;
        end
      end

      default: begin
        nxt_state = IDLE;
        duty_nxt  = 16'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_vi_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_vi_loop_sequencer                                         |
// | Purpose   : Self-checking bench for vi_loop_sequencer (DIV=8). Directed  |
// |             scenarios followed by randomized stimulus, all compared      |
// |             every cycle against a schedule-based reference model.        |
// | Options   : SOFT_START_EN - changes the expected v_ref behaviour.        |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_vi_loop_sequencer;

  localparam int                 DIV  = 8;
  localparam logic signed [15:0] STEP = 16'sh1800;
`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear_fault = 1'b0;
  logic        calc_done = 1'b0;
  logic [15:0] v_ref_tgt = 16'h4000;
  logic [15:0] i_max = 16'h7000;
  logic [15:0] i_in = 16'h0000;
  logic [15:0] duty_in = 16'h2000;
  logic        calc_req, duty_load, fault;
  logic [15:0] duty_out, v_ref;
  logic [1:0]  fault_code;
  logic [2:0]  state;

  vi_loop_sequencer #(.DIV(DIV), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_fault(clear_fault),
    .v_ref_tgt(v_ref_tgt), .i_max(i_max), .i_in(i_in),
    .calc_req(calc_req), .calc_done(calc_done), .duty_in(duty_in),
    .duty_out(duty_out), .duty_load(duty_load), .v_ref(v_ref),
    .fault(fault), .fault_code(fault_code), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit model_valid = 1'b0;

  // Reference model: mode 0 idle, 1 running, 2 fault; samples fall on an
  // absolute edge schedule start_edge + k*DIV.
  int          m_mode = 0;
  bit          m_in_calc = 1'b0;
  int          m_next_tick = 0;
  logic [15:0] m_duty = 16'h0, m_vref = 16'h0;
  bit          m_fault = 1'b0, m_cr = 1'b0, m_dl = 1'b0;
  logic [1:0]  m_code = 2'b00;

  int          cr_q[$];
  logic [15:0] vref_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [15:0] ramp(input logic [15:0] cur_v, input logic [15:0] tgt_v);
    int cur, tg, st;
    if (!SOFT) return tgt_v;
    cur = int'($signed(cur_v));
    tg  = int'($signed(tgt_v));
    st  = int'(STEP);
    if (cur < tg)      cur = (cur + st > tg) ? tg : cur + st;
    else if (cur > tg) cur = (cur - st < tg) ? tg : cur - st;
    return 16'(cur);
  endfunction

  task automatic enter_fault(input logic [1:0] code);
    m_mode = 2; m_fault = 1'b1; m_code = code; m_duty = 16'h0; m_dl = 1'b1;
  endtask

  task automatic model_step();
    bit oc, tick;
    oc = $signed(i_in) > $signed(i_max);
    m_cr = 1'b0;
    m_dl = 1'b0;
    if (rst) begin
      model_valid = 1'b1;
      m_mode = 0; m_in_calc = 1'b0; m_duty = 16'h0; m_vref = 16'h0;
      m_fault = 1'b0; m_code = 2'b00;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1; m_in_calc = 1'b0; m_next_tick = edge_n + DIV;
        m_vref = SOFT ? 16'h0 : v_ref_tgt;
      end
    end else if (m_mode == 1) begin
      tick = (edge_n == m_next_tick);
      if (tick) m_next_tick += DIV;
      if (oc) enter_fault(2'b01);
      else if (tick && m_in_calc) enter_fault(2'b10);
      else if (tick) begin
        m_cr = 1'b1; m_in_calc = 1'b1;
      end else if (m_in_calc && calc_done) begin
        m_in_calc = 1'b0;
        m_duty = ($signed(duty_in) < 0) ? 16'h0 : duty_in;
        m_dl = 1'b1;
        m_vref = ramp(m_vref, v_ref_tgt);
      end
    end else begin
      if (clear_fault && !oc) begin
        m_mode = 0; m_fault = 1'b0; m_code = 2'b00;
      end
    end
  endtask

  function automatic logic [2:0] m_state();
    if (m_mode == 0) return 3'd0;
    if (m_mode == 2) return 3'd3;
    return m_in_calc ? 3'd2 : 3'd1;
  endfunction

  // Model update on each edge, compare 1 time unit later.
  always @(posedge clk) begin
    edge_n++;
    model_step();
    #1;
    if (calc_req) cr_q.push_back(edge_n);
    if (duty_load && !fault) vref_log.push_back(v_ref);
    if (model_valid) begin
      chk("calc_req",   {31'd0, calc_req},  {31'd0, m_cr});
      chk("duty_load",  {31'd0, duty_load}, {31'd0, m_dl});
      chk("duty_out",   {16'd0, duty_out},  {16'd0, m_duty});
      chk("v_ref",      {16'd0, v_ref},     {16'd0, m_vref});
      chk("fault",      {31'd0, fault},     {31'd0, m_fault});
      chk("fault_code", {30'd0, fault_code}, {30'd0, m_code});
      chk("state",      {29'd0, state},     {29'd0, m_state()});
    end
  end

  // PI datapath stand-in: returns calc_done a fixed or random number of
  // cycles after calc_req; in random mode also emits stray strobes.
  bit resp_en = 1'b1;
  bit rand_mode = 1'b0;
  int resp_lat = 2;
  int resp_cnt = -1;
  always @(negedge clk) begin
    calc_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        calc_done = 1'b1;
        resp_cnt = -1;
      end
    end else if (rand_mode && $urandom_range(0, 19) == 0) begin
      calc_done = 1'b1;
    end
    if (calc_req && resp_en)
      resp_cnt = !rand_mode ? resp_lat :
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 10)) : int'($urandom_range(1, 6));
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int f_edge;
    bit ok;
    logic [15:0] exp_vref [4];

    repeat (3) @(negedge clk);
    chk("reset_state",   {29'd0, state}, 32'd0);
    chk("reset_duty",    {16'd0, duty_out}, 32'd0);
    chk("reset_vref",    {16'd0, v_ref}, 32'd0);
    chk("reset_fault",   {29'd0, fault, fault_code}, 32'd0);
    chk("reset_strobes", {30'd0, calc_req, duty_load}, 32'd0);
    rst = 1'b0;

    // Normal run: PI answers 2 cycles after each request with 0x2000.
    cr_q.delete(); vref_log.delete();
    start = 1'b1; @(negedge clk); start = 1'b0; t = edge_n;
    chk("vref_at_start", {16'd0, v_ref}, SOFT ? 32'h0 : 32'h4000);
    repeat (45) @(negedge clk);
    chk("calc_req_count", cr_q.size(), 5);
    if (cr_q.size() > 0) chk("first_calc_req_latency", cr_q[0] - t, DIV);
    for (int i = 1; i < cr_q.size(); i++) chk("calc_req_spacing", cr_q[i] - cr_q[i-1], DIV);
    chk("duty_normal", {16'd0, duty_out}, 32'h2000);
    if (SOFT) begin
      exp_vref[0] = 16'h1800; exp_vref[1] = 16'h3000; exp_vref[2] = 16'h4000; exp_vref[3] = 16'h4000;
    end else begin
      exp_vref[0] = 16'h4000; exp_vref[1] = 16'h4000; exp_vref[2] = 16'h4000; exp_vref[3] = 16'h4000;
    end
    chk("vref_log_count", vref_log.size(), 5);
    for (int i = 0; i < 4 && i < vref_log.size(); i++) chk("vref_sequence", {16'd0, vref_log[i]}, {16'd0, exp_vref[i]});

    // Negative PI result clamps to zero.
    duty_in = 16'hC000;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = duty_load;
    end
    chk("clamp_load_seen", {31'd0, ok}, 32'd1);
    chk("clamp_duty", {16'd0, duty_out}, 32'd0);
    duty_in = 16'h2000;

    // Over-current mid-run, then clears with and without the condition.
    i_in = 16'h7999;
    @(negedge clk);
    chk("oc_fault", {31'd0, fault}, 32'd1);
    chk("oc_code", {30'd0, fault_code}, 32'd1);
    chk("oc_duty", {16'd0, duty_out}, 32'd0);
    chk("oc_duty_load", {31'd0, duty_load}, 32'd1);
    clear_fault = 1'b1;
    @(negedge clk);
    chk("oc_clear_ignored", {29'd0, state}, 32'd3);
    i_in = 16'h0000;
    @(negedge clk);
    chk("oc_clear_state", {29'd0, state}, 32'd0);
    chk("oc_clear_fault", {29'd0, fault, fault_code}, 32'd0);
    clear_fault = 1'b0;

    // Overrun: PI never answers.
    resp_en = 1'b0;
    @(negedge clk);
    cr_q.delete();
    start = 1'b1; @(negedge clk); start = 1'b0; t = edge_n;
    f_edge = -1;
    for (int i = 0; i < 40 && f_edge < 0; i++) begin
      @(negedge clk);
      if (fault) f_edge = edge_n;
    end
    chk("overrun_edge", f_edge - t, 2 * DIV);
    chk("overrun_code", {30'd0, fault_code}, 32'd2);
    chk("overrun_calc_req_count", cr_q.size(), 1);
    clear_fault = 1'b1; @(negedge clk); clear_fault = 1'b0;
    resp_en = 1'b1;

    // Reset while in CALC, then a fresh start.
    resp_lat = 5;
    start = 1'b1; @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (state == 3'd2) && (duty_out != 16'h0);
    end
    chk("reached_calc", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midcalc_rst_state", {29'd0, state}, 32'd0);
    chk("midcalc_rst_duty", {16'd0, duty_out}, 32'd0);
    chk("midcalc_rst_vref", {16'd0, v_ref}, 32'd0);
    chk("midcalc_rst_fault", {29'd0, fault, fault_code}, 32'd0);
    chk("midcalc_rst_strobes", {30'd0, calc_req, duty_load}, 32'd0);
    rst = 1'b0;
    resp_cnt = -1;
    cr_q.delete();
    start = 1'b1; @(negedge clk); start = 1'b0; t = edge_n;
    repeat (10) @(negedge clk);
    chk("restart_first_calc_req", (cr_q.size() > 0) ? cr_q[0] - t : -1, DIV);
    resp_lat = 2;

    // Randomized phase.
    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 3) == 0);
      clear_fault = ($urandom_range(0, 4) == 0);
      duty_in     = 16'($urandom());
      if ($urandom_range(0, 49) == 0) i_max = 16'($urandom_range(16'h3000, 16'h7000));
      if ($urandom_range(0, 29) == 0) v_ref_tgt = 16'($urandom());
      if ($urandom_range(0, 59) == 0) i_in = 16'h7800;
      else i_in = 16'($urandom_range(0, 16'h5FFF)) - 16'h2000;
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vi_loop_sequencer.md
VI_LOOP_SEQUENCER -- requirements
Module: vi_loop_sequencer

Interface
REQ-001 Parameter DIV, default 1000, sample period in clk cycles (100 kHz loop at 100 MHz); legal range 4..65535.
REQ-002 Parameter RAMP_STEP, default 16'sh0020, Q1.15 soft-start increment per sample.
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  level-sampled run request; acted on only in IDLE.
REQ-006 Port clear_fault  input  1  fault acknowledge; acted on only in FAULT.
REQ-007 Port v_ref_tgt  input  16  signed Q1.15 target voltage reference.
REQ-008 Port i_max  input  16  signed Q1.15 over-current threshold.
REQ-009 Port i_in  input  16  signed Q1.15 current sample.
REQ-010 Port calc_req  output  1  one-cycle strobe to the PI datapath.
REQ-011 Port calc_done  input  1  one-cycle PI completion strobe.
REQ-012 Port duty_in  input  16  signed Q1.15 PI result.
REQ-013 Port duty_out  output  16  Q1.15 duty to the PWM, held between loads.
REQ-014 Port duty_load  output  1  one-cycle strobe, high in the first cycle a new duty_out is visible.
REQ-015 Port v_ref  output  16  signed Q1.15 reference presented to the PI.
REQ-016 Port fault  output  1  latched fault flag.
REQ-017 Port fault_code  output  2  00 none, 01 over-current, 10 overrun.
REQ-018 Port state  output  3  current FSM state encoding, for status readback.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, WAIT_TICK, CALC, FAULT.
- IDLE -> WAIT_TICK when start=1 is sampled at edge t.
- The tick counter SHALL load DIV-1 at t.
- The first calc_req SHALL be high in cycle t+DIV; later calc_req pulses SHALL be exactly DIV cycles apart.
REQ-020 The tick counter SHALL free-run modulo DIV while in WAIT_TICK or CALC.
- Each terminal count SHALL raise calc_req for one cycle and move WAIT_TICK -> CALC.
REQ-021 In CALC, calc_done=1 SHALL return the FSM to WAIT_TICK.
- duty_out SHALL update with duty_load=1 in the next cycle.
- duty_out = duty_in clamped to [0, 16'h7FFF]; negative values give 0.
- calc_done outside CALC SHALL be ignored.
REQ-022 A terminal count while still in CALC SHALL enter FAULT with fault_code=10 (overrun).
REQ-023 In WAIT_TICK or CALC, signed i_in > i_max SHALL enter FAULT with fault_code=01 at the next edge.
- Priority: over-current > overrun > calc_done.
REQ-024 On entering FAULT, in the same cycle:
- fault SHALL be 1.
- duty_out SHALL be 0.
- duty_load SHALL pulse.
- calc_req SHALL be suppressed.
REQ-025 FAULT -> IDLE only when clear_fault=1 and i_in <= i_max.
- fault and fault_code SHALL clear on that transition.
- A clear while over-current persists SHALL be ignored.
REQ-026 In IDLE, duty_out SHALL be 0 and no strobes SHALL be asserted.
- start outside IDLE SHALL be ignored.
- start and clear_fault high together in FAULT: only the clear takes effect.
REQ-027 All Q1.15 adds/subtracts SHALL use 17-bit intermediates and saturate to [16'sh8000, 16'sh7FFF]; no wrap-around.

Reset
REQ-028 rst=1 at any edge, including mid-CALC or in FAULT, SHALL force the following, and rst SHALL dominate every other input:
- state IDLE
- counter 0
- duty_out 0, v_ref 0
- fault 0, fault_code 00
- calc_req 0, duty_load 0

Configuration
REQ-029 With SOFT_START_EN defined:
- v_ref SHALL load 0 on start.
- On each calc_done in CALC, v_ref SHALL step by RAMP_STEP toward v_ref_tgt (up or down) and clamp exactly at the target without overshoot.
- A mid-run target change SHALL be tracked from the current v_ref.
REQ-030 Without SOFT_START_EN:
- v_ref SHALL load v_ref_tgt on start and on every calc_done in CALC.
- RAMP_STEP SHALL be unused.

Structure
REQ-031 Package vi_ctrl_pkg SHALL hold:
- the state enum
- the fault_code enum
- Q15_MAX/Q15_MIN constants
- a saturating Q1.15 add function

Both this block and the datapath import it.
REQ-032 Sub-module q15_ramp (current, target, step -> next) SHALL implement REQ-029; it is instantiated only under SOFT_START_EN.

Verification
REQ-033 Normal run: DIV=8, start pulse, calc_done returned 2 cycles after each calc_req with duty_in=16'h2000.
- Required: calc_req every 8 cycles.
- Required: duty_out=16'h2000 with duty_load one cycle after each calc_done.
REQ-034 Clamp: duty_in=16'hC000 -> duty_out=0.
REQ-035 Over-current: i_max=16'h7000, i_in=16'h7999 mid-run.
- Required next cycle: fault=1, fault_code=01, duty_out=0.
- clear_fault with i_in still high -> remains in FAULT.
- clear_fault with i_in=0 -> IDLE, fault=0.
REQ-036 Overrun: calc_done withheld past 8 cycles -> FAULT with fault_code=10 at the second terminal count, and no calc_req pulse.
REQ-037 Soft-start (SOFT_START_EN): v_ref_tgt=16'h4000, RAMP_STEP=16'h1800.
- Required v_ref sequence: 0, 16'h1800, 16'h3000, 16'h4000, 16'h4000.
- Without the macro, v_ref=16'h4000 from start.
REQ-038 Reset: rst asserted mid-CALC -> all outputs at reset values next cycle; a later start restarts the period from zero.
